// File: rtl/interleaver_pkg.sv
// -----------------------------------------------------------------------------
// interleaver_pkg
//   Shared constants and types for the convolutional interleaver front end.
//   BRANCHES_DEF / DATA_W_DEF : default branch count and word width
//   SYNC_BYTE                 : MPEG-TS sync byte value seen on in_sync words
//   branch_idx_t              : branch index type for the default branch count
// -----------------------------------------------------------------------------
package interleaver_pkg;
   localparam int         BRANCHES_DEF = 12;
   localparam int         DATA_W_DEF   = 8;
   localparam logic [7:0] SYNC_BYTE    = 8'h47;
   localparam int         SEL_W_DEF    = $clog2(BRANCHES_DEF);

   typedef logic [SEL_W_DEF-1:0] branch_idx_t;
endpackage

// File: rtl/commutator_counter.sv
// -----------------------------------------------------------------------------
// commutator_counter
//   Modulo-BRANCHES branch pointer for the commutator.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset (pointer -> 0)
//     i_inc        : advance pointer by one, wrapping BRANCHES-1 -> 0
//     i_load       : load i_load_val (takes priority over i_inc)
//     i_load_val   : value loaded on i_load
//     o_ptr        : registered pointer
// -----------------------------------------------------------------------------
module commutator_counter
   import interleaver_pkg::*;
#(
   parameter int BRANCHES = BRANCHES_DEF,
   parameter int SEL_W    = $clog2(BRANCHES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_load,
   input  logic [SEL_W-1:0] i_load_val,
   output logic [SEL_W-1:0] o_ptr
);

   logic [SEL_W-1:0] r_ptr;
   logic [SEL_W-1:0] w_ptr_nxt;

   always_comb begin
      w_ptr_nxt = r_ptr;
      if (i_load) begin
         w_ptr_nxt = i_load_val;
      end else if (i_inc) begin
         w_ptr_nxt = (int'(r_ptr) == BRANCHES - 1) ? '0 : r_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else begin
         r_ptr <= w_ptr_nxt;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/interleaver_commutator_demux.sv
// -----------------------------------------------------------------------------
// interleaver_commutator_demux
//   Registered 1-to-BRANCHES word commutator feeding the per-branch delay FIFOs
//   of a convolutional interleaver. One cycle latency, held branch outputs.
//   Optional feature macro: SYNC_ALIGN_EN (sync words realign the pointer to
//   branch 0 in auto mode and flag a slip when the pointer was elsewhere).
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     in_data     : input word            in_valid  : input word valid
//     in_ready    : word accepted this cycle (combinational from target)
//     auto_mode   : 1 = internal pointer, 0 = sel_in chooses the branch
//     sel_in      : manual branch index   in_sync   : word is a sync byte
//     br_ready    : per-branch downstream ready
//     br_data     : packed held branch words, branch i at [i*DATA_W +: DATA_W]
//     br_valid    : one-cycle load strobe per branch
//     cur_branch  : registered auto-mode pointer
//     sel_err     : pulse, manual select was out of range (word dropped)
//     sync_slip   : pulse, sync word arrived while pointer was not on branch 0
// -----------------------------------------------------------------------------
module interleaver_commutator_demux
   import interleaver_pkg::*;
#(
   parameter int BRANCHES = BRANCHES_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int SEL_W    = $clog2(BRANCHES)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       auto_mode,
   input  logic [SEL_W-1:0]           sel_in,
   input  logic                       in_sync,
   input  logic [BRANCHES-1:0]        br_ready,
   output logic [BRANCHES*DATA_W-1:0] br_data,
   output logic [BRANCHES-1:0]        br_valid,
   output logic [SEL_W-1:0]           cur_branch,
   output logic                       sel_err,
   output logic                       sync_slip
);

   localparam logic [SEL_W-1:0] PTR_AFTER_SYNC = SEL_W'(1);

   logic [SEL_W-1:0]    w_ptr;
   logic [SEL_W-1:0]    w_tgt;
   logic                w_tgt_ok;
   logic                w_sync_hit;
   logic                w_xfer;
   logic                w_hit;
   logic                w_inc;
   logic                w_load;
   logic [BRANCHES-1:0] w_strobe_nxt;

   logic [DATA_W-1:0]   r_br_data_p1 [BRANCHES];
   logic [BRANCHES-1:0] r_br_valid_p1;
   logic                r_sel_err_p1;
   logic                r_sync_slip_p1;

`ifdef SYNC_ALIGN_EN
   assign w_sync_hit = auto_mode & in_sync;
`else
   // in_sync is intentionally ignored in this build
   logic w_unused_sync;
   assign w_unused_sync = in_sync;
   assign w_sync_hit    = 1'b0;
`endif

   // Sync words in auto mode always go to branch 0 regardless of the pointer
   assign w_tgt    = !auto_mode ? sel_in : (w_sync_hit ? '0 : w_ptr);
   assign w_tgt_ok = int'(w_tgt) < BRANCHES;

   // Out-of-range manual selects are accepted so the bad word is drained
   assign in_ready = w_tgt_ok ? br_ready[w_tgt] : 1'b1;
   assign w_xfer   = in_valid & in_ready;
   assign w_hit    = w_xfer & w_tgt_ok;

   // Pointer only moves on auto-mode transfers; manual mode leaves it frozen
   assign w_inc  = w_xfer & auto_mode & ~w_sync_hit;
   assign w_load = w_xfer & w_sync_hit;

   always_comb begin
      w_strobe_nxt = '0;
      if (w_hit) begin
         w_strobe_nxt[w_tgt] = 1'b1;
      end
   end

   commutator_counter #(
      .BRANCHES (BRANCHES),
      .SEL_W    (SEL_W)
   ) u_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_inc      (w_inc),
      .i_load     (w_load),
      .i_load_val (PTR_AFTER_SYNC),
      .o_ptr      (w_ptr)
   );

   // ---- stage p1: branch registers and one-cycle flags ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_br_valid_p1  <= '0;
         r_sel_err_p1   <= 1'b0;
         r_sync_slip_p1 <= 1'b0;
         for (int i = 0; i < BRANCHES; i++) begin
            r_br_data_p1[i] <= '0;
         end
      end else begin
         r_br_valid_p1  <= w_strobe_nxt;
         r_sel_err_p1   <= w_xfer & ~w_tgt_ok;
         r_sync_slip_p1 <= w_load & (w_ptr != '0);
         for (int i = 0; i < BRANCHES; i++) begin
            if (w_strobe_nxt[i]) begin
               r_br_data_p1[i] <= in_data;
            end
         end
      end
   end

   for (genvar g = 0; g < BRANCHES; g++) begin : g_pack
      assign br_data[g*DATA_W +: DATA_W] = r_br_data_p1[g];
   end

   assign br_valid   = r_br_valid_p1;
   assign sel_err    = r_sel_err_p1;
   assign sync_slip  = r_sync_slip_p1;
   assign cur_branch = w_ptr;

endmodule
